// File: rtl/ped_walk_arbiter.sv
// Pedestrian walk arbiter: captures and debounces two crosswalk buttons,
// arbitrates them round-robin, and serves granted requests only inside
// all-red phases while holding the traffic-light sequencer.
// Build option: define PED_FLASH_EN to flash the walk lamp during clearance.
module ped_walk_arbiter #(
    parameter int unsigned TIME_SZ   = 4,
    parameter int unsigned WALK_LEN  = 5,
    parameter int unsigned CLR_LEN   = 2,
    parameter int unsigned DB_CYCLES = 25000000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               tick_i,
    input  logic [1:0]         req_i,
    input  logic [2:0]         phase_i,
    output logic               hold_o,
    output logic [1:0]         walk_o,
    output logic [TIME_SZ-1:0] walk_time_o,
    output logic [1:0]         pend_o
);

    localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [TIME_SZ-1:0] WALK_T = TIME_SZ'(WALK_LEN);
    localparam logic [TIME_SZ-1:0] CLR_T  = TIME_SZ'(CLR_LEN);
    localparam logic [DB_W-1:0]    DB_T   = DB_W'(DB_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WALK  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Lamp pattern for a crosswalk index.
    function automatic logic [1:0] lamp(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

    logic [1:0]         sync1, sync2, sync_prev;
    logic [1:0]         rise, accept;
    logic [DB_W-1:0]    db_cnt [2];
    logic [1:0]         pend_q, pend_clr;

    state_t             state_q, state_d;
    logic               hold_q, hold_d;
    logic [1:0]         walk_q, walk_d;
    logic [TIME_SZ-1:0] time_q, time_d;
    logic               gnt_q, gnt_d;
    logic               lp_q, lp_d;
    logic               other_g;
    logic               allred;

    // Two-flop synchronizer plus a delayed copy for rising-edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1     <= 2'b00;
            sync2     <= 2'b00;
            sync_prev <= 2'b00;
        end else begin
            sync1     <= req_i;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // A press counts only when its button is out of hold-off.
    always_comb begin
        rise = sync2 & ~sync_prev;
        for (int n = 0; n < 2; n++) begin
            accept[n] = rise[n] && (db_cnt[n] == '0);
        end
    end

    // Per-button hold-off counters, reloaded on every accepted press.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < 2; n++) begin
                db_cnt[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (accept[n]) begin
                    db_cnt[n] <= DB_T;
                end else if (db_cnt[n] != '0) begin
                    db_cnt[n] <= db_cnt[n] - DB_W'(1);
                end
            end
        end
    end

    // Pending flags: a new press beats a same-cycle completion clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= 2'b00;
        end else begin
            pend_q <= (pend_q & ~pend_clr) | accept;
        end
    end

    assign allred  = (phase_i == 3'd2) || (phase_i == 3'd5);
    assign other_g = ~gnt_q;

    // Service FSM state and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            hold_q  <= 1'b0;
            walk_q  <= 2'b00;
            time_q  <= '0;
            gnt_q   <= 1'b0;
            lp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            walk_q  <= walk_d;
            time_q  <= time_d;
            gnt_q   <= gnt_d;
            lp_q    <= lp_d;
        end
    end

    // Next-state and next-output logic for the service episode.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        walk_d   = walk_q;
        time_d   = time_q;
        gnt_d    = gnt_q;
        lp_d     = lp_q;
        pend_clr = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (allred && (pend_q != 2'b00)) begin
                    gnt_d   = (pend_q == 2'b11) ? ~lp_q : pend_q[1];
                    state_d = ST_WALK;
                    hold_d  = 1'b1;
                    walk_d  = lamp(gnt_d);
                    time_d  = WALK_T;
                end
            end

            ST_WALK: begin
                if (tick_i) begin
                    if (time_q == '0) begin
                        state_d  = ST_CLEAR;
                        time_d   = CLR_T;
                        pend_clr = lamp(gnt_q);
                        lp_d     = gnt_q;
`ifdef PED_FLASH_EN
                        walk_d   = lamp(gnt_q);
`else
                        walk_d   = 2'b00;
`endif
                    end else begin
                        time_d = time_q - TIME_SZ'(1);
                    end
                end
            end

            ST_CLEAR: begin
                if (tick_i) begin
                    if (time_q == '0) begin
                        if (pend_q[other_g]) begin
                            gnt_d   = other_g;
                            state_d = ST_WALK;
                            walk_d  = lamp(other_g);
                            time_d  = WALK_T;
                        end else begin
                            state_d = ST_DONE;
                            hold_d  = 1'b0;
                            walk_d  = 2'b00;
                            time_d  = '0;
                        end
                    end else begin
                        time_d = time_q - TIME_SZ'(1);
`ifdef PED_FLASH_EN
                        walk_d = walk_q ^ lamp(gnt_q);
`endif
                    end
                end
            end

            ST_DONE: begin
                if (!allred) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign hold_o      = hold_q;
    assign walk_o      = walk_q;
    assign walk_time_o = time_q;
    assign pend_o      = pend_q;

endmodule

// File: tb/tb_ped_walk_arbiter.sv
// Self-checking bench for ped_walk_arbiter: directed scenarios plus a
// randomized episode check against a tick-by-tick expectation list.
module tb_ped_walk_arbiter;

    localparam int unsigned TS = 4;
    localparam int unsigned W  = 3;
    localparam int unsigned DB = 4;
`ifdef PED_FLASH_EN
    localparam int unsigned C     = 3;
    localparam bit          FLASH = 1'b1;
`else
    localparam int unsigned C     = 1;
    localparam bit          FLASH = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          tick_i;
    logic [1:0]    req_i;
    logic [2:0]    phase_i;
    logic          hold_o;
    logic [1:0]    walk_o;
    logic [TS-1:0] walk_time_o;
    logic [1:0]    pend_o;
    logic [8:0]    obs;

    int checks = 0;
    int errors = 0;
    int lp_m   = 1;
    int na [6] = '{0, 1, 3, 4, 6, 7};

    ped_walk_arbiter #(
        .TIME_SZ  (TS),
        .WALK_LEN (W),
        .CLR_LEN  (C),
        .DB_CYCLES(DB)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .tick_i     (tick_i),
        .req_i      (req_i),
        .phase_i    (phase_i),
        .hold_o     (hold_o),
        .walk_o     (walk_o),
        .walk_time_o(walk_time_o),
        .pend_o     (pend_o)
    );

    always #5 clk_i = ~clk_i;

    // Observed vector: hold | walk[1:0] | time | pend[1:0]
    assign obs = {hold_o, walk_o, walk_time_o, pend_o};

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_tick();
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic press(input logic [1:0] b);
        req_i = b;
        step();
        req_i = 2'b00;
        repeat (9) step();
    endtask

    function automatic logic [1:0] lamp(input int g);
        return (g == 1) ? 2'b10 : 2'b01;
    endfunction

    // Walk lamp after j ticks of clearance for crosswalk g.
    function automatic logic [1:0] clr_lamp(input int g, input int j);
        if (FLASH && ((j % 2) == 0)) return lamp(g);
        return 2'b00;
    endfunction

    task automatic test_reset();
        logic [8:0] e;
        bit found;
        rst_i = 1'b1; req_i = 2'b11; phase_i = 3'd2; tick_i = 1'b1;
        repeat (3) step();
        e = 9'b0;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_held got %b want %b", obs, e); end
        tick_i = 1'b0; req_i = 2'b00; phase_i = 3'd0;
        step();
        rst_i = 1'b0;
        repeat (3) step();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_release got %b want %b", obs, e); end
        req_i = 2'b01;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) req_i = 2'b00;
            if (pend_o == 2'b01) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL press_latency got pend=%b want 01 within 4 clk", pend_o); end
        repeat (8) step();
        lp_m = 1;
    endtask

    task automatic test_single_walk();
        logic [8:0] e;
        phase_i = 3'd2;
        step();
        e = {1'b1, 2'b01, TS'(W), 2'b01};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL single_entry got %b want %b", obs, e); end
        repeat (2) step();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL single_no_tick got %b want %b", obs, e); end
        for (int k = 1; k <= int'(W); k++) begin
            do_tick();
            e = {1'b1, 2'b01, TS'(int'(W) - k), 2'b01};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL single_walk_%0d got %b want %b", k, obs, e); end
        end
        do_tick();
        e = {1'b1, clr_lamp(0, 0), TS'(C), 2'b00};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL single_clear_entry got %b want %b", obs, e); end
        for (int j = 1; j <= int'(C); j++) begin
            do_tick();
            e = {1'b1, clr_lamp(0, j), TS'(int'(C) - j), 2'b00};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL single_clear_%0d got %b want %b", j, obs, e); end
        end
        do_tick();
        run_ticks(2);
        e = 9'b0;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL single_done got %b want %b", obs, e); end
        lp_m = 0;
        phase_i = 3'd0;
        step();
    endtask

    task automatic test_non_allred();
        logic [8:0] e;
        press(2'b01);
        for (int i = 0; i < 6; i++) begin
            phase_i = 3'(na[i]);
            step();
            do_tick();
            e = {1'b0, 2'b00, TS'(0), 2'b01};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL nonallred_phase%0d got %b want %b", na[i], obs, e); end
        end
        phase_i = 3'd2;
        step();
        run_ticks(int'(W) + 1 + int'(C) + 1);
        press(2'b10);
        run_ticks(3);
        e = {1'b0, 2'b00, TS'(0), 2'b10};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL done_blocks_regrant got %b want %b", obs, e); end
        phase_i = 3'd0;
        step();
        phase_i = 3'd5;
        step();
        e = {1'b1, 2'b10, TS'(W), 2'b10};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL next_allred_grant got %b want %b", obs, e); end
        run_ticks(int'(W) + 1 + int'(C) + 1);
        e = 9'b0;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL b_served got %b want %b", obs, e); end
        lp_m = 1;
        phase_i = 3'd0;
        step();
    endtask

    task automatic test_both();
        logic [8:0] e;
        press(2'b11);
        phase_i = 3'd5;
        step();
        e = {1'b1, 2'b01, TS'(W), 2'b11};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL both_first_a got %b want %b", obs, e); end
        run_ticks(int'(W) + 1);
        e = {1'b1, clr_lamp(0, 0), TS'(C), 2'b10};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL both_a_clear got %b want %b", obs, e); end
        run_ticks(int'(C) + 1);
        e = {1'b1, 2'b10, TS'(W), 2'b10};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL both_then_b got %b want %b", obs, e); end
        run_ticks(int'(W) + 1 + int'(C));
        e = {1'b1, clr_lamp(1, int'(C)), TS'(0), 2'b00};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL both_b_clear_end got %b want %b", obs, e); end
        do_tick();
        e = 9'b0;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL both_done got %b want %b", obs, e); end
        lp_m = 1;
        phase_i = 3'd0;
        step();
    endtask

    task automatic test_debounce();
        logic [8:0] e;
        press(2'b01);
        phase_i = 3'd2;
        step();
        run_ticks(int'(W));
        req_i = 2'b01; step();
        req_i = 2'b00; step();
        req_i = 2'b01; step();
        req_i = 2'b00; tick_i = 1'b1; step();
        tick_i = 1'b0;
        e = {1'b1, clr_lamp(0, 0), TS'(C), 2'b00};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL db_clear got %b want %b", obs, e); end
        step();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL db_ignored got %b want %b", obs, e); end
        req_i = 2'b01; step();
        req_i = 2'b00; step();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL db_not_yet got %b want %b", obs, e); end
        step();
        e = {1'b1, clr_lamp(0, 0), TS'(C), 2'b01};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL db_accepted got %b want %b", obs, e); end
        run_ticks(int'(C) + 1);
        phase_i = 3'd0;
        step();
        phase_i = 3'd2;
        step();
        run_ticks(int'(W));
        req_i = 2'b01; step();
        req_i = 2'b00; step();
        tick_i = 1'b1; step();
        tick_i = 1'b0;
        e = {1'b1, clr_lamp(0, 0), TS'(C), 2'b01};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL set_beats_clear got %b want %b", obs, e); end
        run_ticks(int'(C) + 1);
        e = {1'b0, 2'b00, TS'(0), 2'b01};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL collision_done got %b want %b", obs, e); end
        phase_i = 3'd0;
        step();
        phase_i = 3'd2;
        step();
        run_ticks(int'(W) + 1 + int'(C) + 1);
        lp_m = 0;
        phase_i = 3'd0;
        step();
    endtask

    task automatic test_reset_mid();
        logic [8:0] e;
        press(2'b10);
        phase_i = 3'd5;
        step();
        do_tick();
        rst_i = 1'b1;
        #1;
        e = 9'b0;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_async got %b want %b", obs, e); end
        step();
        rst_i = 1'b0;
        repeat (3) step();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_mid_lost got %b want %b", obs, e); end
        lp_m = 1;
        phase_i = 3'd0;
        step();
    endtask

    task automatic test_random();
        logic [8:0] e;
        logic [8:0] q[$];
        logic [1:0] pm;
        int seq[$];
        int sel, f, g;
        for (int it = 0; it < 24; it++) begin
            sel = int'($urandom_range(0, 3));
            phase_i = 3'(na[$urandom_range(0, 5)]);
            press(2'(sel));
            repeat ($urandom_range(1, 4)) step();
            e = {1'b0, 2'b00, TS'(0), 2'(sel)};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL rnd%0d_wait got %b want %b", it, obs, e); end
            phase_i = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd5;
            step();
            if (sel == 0) begin
                run_ticks(3);
                e = 9'b0;
                checks++;
                if (obs !== e) begin errors++; $display("FAIL rnd%0d_idle got %b want %b", it, obs, e); end
            end else begin
                seq.delete();
                q.delete();
                if (sel == 3) begin
                    f = (lp_m == 1) ? 0 : 1;
                    seq.push_back(f);
                    seq.push_back(1 - f);
                end else begin
                    seq.push_back((sel == 2) ? 1 : 0);
                end
                pm = 2'(sel);
                e = {1'b1, lamp(seq[0]), TS'(W), pm};
                checks++;
                if (obs !== e) begin errors++; $display("FAIL rnd%0d_entry got %b want %b", it, obs, e); end
                for (int i = 0; i < seq.size(); i++) begin
                    g = seq[i];
                    for (int k = 1; k <= int'(W); k++) q.push_back({1'b1, lamp(g), TS'(int'(W) - k), pm});
                    pm[g] = 1'b0;
                    q.push_back({1'b1, clr_lamp(g, 0), TS'(C), pm});
                    for (int j = 1; j <= int'(C); j++) q.push_back({1'b1, clr_lamp(g, j), TS'(int'(C) - j), pm});
                    if (i + 1 < seq.size()) q.push_back({1'b1, lamp(seq[i + 1]), TS'(W), pm});
                    else q.push_back({1'b0, 2'b00, TS'(0), pm});
                end
                lp_m = seq[seq.size() - 1];
                for (int n = 0; n < q.size(); n++) begin
                    repeat ($urandom_range(0, 2)) step();
                    if ($urandom_range(0, 9) == 0) phase_i = 3'(na[$urandom_range(0, 5)]);
                    do_tick();
                    checks++;
                    if (obs !== q[n]) begin errors++; $display("FAIL rnd%0d_tick%0d got %b want %b", it, n, obs, q[n]); end
                end
            end
            phase_i = 3'(na[$urandom_range(0, 5)]);
            repeat (2) step();
        end
    endtask

    initial begin
        test_reset();
        test_single_walk();
        test_non_allred();
        test_both();
        test_debounce();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
